// File: rtl/cp0_exc_ctrl_if.sv
// Bundle of M-stage, CP0 and redirect signals shared by the exception
// sequencer (master) and the pipeline/CP0 side (slave).
interface cp0_exc_ctrl_if;
    // M-stage / CP0 state inputs to the sequencer
    logic [31:0] sr;
    logic [31:0] epc;
    logic [31:0] pc_m;
    logic        valid_m;
    logic        stall_m;
    logic        bd_m;
    logic        exc_valid_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    // CP0 write-side outputs
    logic        cp0_we1;
    logic        cp0_we2;
    logic [4:0]  cp0_ex;
    logic        cp0_bd;
    logic [31:0] cp0_epc_in;
    logic [5:0]  cp0_hwint;
    // pipeline control outputs
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        input  sr, epc, pc_m, valid_m, stall_m, bd_m, exc_valid_m, exc_code_m, eret_m,
        output cp0_we1, cp0_we2, cp0_ex, cp0_bd, cp0_epc_in, cp0_hwint,
        output flush, redirect_valid, redirect_pc
    );

    modport slave (
        output sr, epc, pc_m, valid_m, stall_m, bd_m, exc_valid_m, exc_code_m, eret_m,
        input  cp0_we1, cp0_we2, cp0_ex, cp0_bd, cp0_epc_in, cp0_hwint,
        input  flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer. Watches the M-stage instruction, SR and
// synchronized device interrupts; issues the CP0 entry (we1) and eret (we2)
// strobes, redirects the PC and flushes the pipeline. The FSM rather than
// SR.EXL blocks re-entry, so the cycle before the EXL write lands is covered.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          SYNC_STAGES  = 2              // 1..3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            hwint_raw,
    cp0_exc_ctrl_if.master        bus,
    output logic                  double_fault
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HANDLER = 2'd1,
        S_RETURN  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   double_fault_q, double_fault_d;
    logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;

    logic int_req, exc_req, take, do_eret;

    // interrupt synchronizer: stage 0 samples the raw lines, each stage shifts up
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = hwint_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // synchronizer flops
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign bus.cp0_hwint = sync_q[SYNC_STAGES-1];

    // request qualification, next state and strobe generation
    always_comb begin
        state_d            = state_q;
        bus.cp0_we1        = 1'b0;
        bus.cp0_we2        = 1'b0;
        bus.cp0_ex         = 5'd0;
        bus.cp0_bd         = 1'b0;
        bus.cp0_epc_in     = bus.pc_m;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        int_req = (state_q == S_IDLE) & bus.sr[0] & ~bus.sr[1]
                & (|(sync_q[SYNC_STAGES-1] & bus.sr[15:10]));
        exc_req = (state_q == S_IDLE) & bus.exc_valid_m;
        // a request blocked by a bubble or stall simply re-evaluates next cycle
        take    = (int_req | exc_req) & bus.valid_m & ~bus.stall_m & ~reset;
        do_eret = (state_q == S_HANDLER) & bus.eret_m & bus.valid_m
                & ~bus.stall_m & ~reset;

        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    bus.cp0_we1        = 1'b1;
                    // interrupt wins over a same-cycle exception
                    bus.cp0_ex         = int_req ? 5'd0 : bus.exc_code_m;
                    bus.cp0_bd         = bus.bd_m;
                    bus.flush          = 1'b1;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = HANDLER_ADDR;
                    state_d            = S_HANDLER;
                end
            end
            S_HANDLER: begin
                if (do_eret) begin
                    bus.cp0_we2        = 1'b1;
                    bus.flush          = 1'b1;
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = bus.epc;
                    state_d            = S_RETURN;
                end
            end
            // one quiet cycle so the EXL clear reaches SR before re-arming
            S_RETURN:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (reset) state_d = S_IDLE;
    end

    // sticky double-fault: an exception arriving while already in the handler
    always_comb begin
        double_fault_d = double_fault_q
                       | ((state_q == S_HANDLER) & bus.exc_valid_m & bus.valid_m);
        if (reset) double_fault_d = 1'b0;
    end

    // state and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            double_fault_q <= double_fault_d;
        end
    end

    assign double_fault = double_fault_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: a directed per-cycle vector table covering the
// entry/eret/double-fault/reset/stall scenarios, then randomized cycles
// checked against a behavioural model of the sequencer.
module tb_cp0_exc_ctrl;
    localparam int          S  = 2;
    localparam logic [31:0] HA = 32'h0000_4180;
    localparam logic [31:0] A  = 32'h0000_0401;   // IM[10] + IE

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] hwint_raw;
    logic       double_fault;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.HANDLER_ADDR(HA), .SYNC_STAGES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .hwint_raw    (hwint_raw),
        .bus          (bus),
        .double_fault (double_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  hw;
        logic [31:0] sr;
        logic        vld, stl, bd, exc;
        logic [4:0]  code;
        logic        eret;
        logic [31:0] pc, epc;
        logic        we1, we2;
        logic [4:0]  ex;
        logic        ebd;
        logic [5:0]  ehw;
        logic [31:0] rpc;
        logic        df;
    } vec_t;

    function automatic vec_t V(
        input logic rst, input logic [5:0] hw, input logic [31:0] sr,
        input logic vld, input logic stl, input logic bd, input logic exc,
        input logic [4:0] code, input logic eret, input logic [31:0] pc,
        input logic [31:0] epc, input logic we1, input logic we2,
        input logic [4:0] ex, input logic ebd, input logic [5:0] ehw,
        input logic [31:0] rpc, input logic df);
        vec_t v;
        v.rst = rst; v.hw = hw; v.sr = sr; v.vld = vld; v.stl = stl; v.bd = bd;
        v.exc = exc; v.code = code; v.eret = eret; v.pc = pc; v.epc = epc;
        v.we1 = we1; v.we2 = we2; v.ex = ex; v.ebd = ebd; v.ehw = ehw;
        v.rpc = rpc; v.df = df;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic [5:0] hw, input logic [31:0] sr,
                         input logic vld, input logic stl, input logic bd,
                         input logic exc, input logic [4:0] code, input logic eret,
                         input logic [31:0] pc, input logic [31:0] epc);
        reset = rst; hwint_raw = hw; bus.sr = sr; bus.valid_m = vld;
        bus.stall_m = stl; bus.bd_m = bd; bus.exc_valid_m = exc;
        bus.exc_code_m = code; bus.eret_m = eret; bus.pc_m = pc; bus.epc = epc;
    endtask

    // outputs packed as {we1,we2,ex,bd,epc_in,hwint,flush,rv,rpc,df}
    function automatic logic [80:0] got_vec();
        return {bus.cp0_we1, bus.cp0_we2, bus.cp0_ex, bus.cp0_bd, bus.cp0_epc_in,
                bus.cp0_hwint, bus.flush, bus.redirect_valid, bus.redirect_pc,
                double_fault};
    endfunction

    task automatic check(input string nm, input logic [80:0] got, input logic [80:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    vec_t tbl[27];

    // behavioural model state
    bit         busy, cool, mdf;
    logic [5:0] hq[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        //            rst hw sr vld stl bd exc code eret pc        epc      | we1 we2 ex bd hw rpc        df
        tbl[0]  = V(1, 0, 0, 0, 0, 0, 0, 0,  0, 32'h0,    32'h0,    0, 0, 0,  0, 0, 32'h0,    0);
        // interrupt entry, exactly S cycles after the raw line rises
        tbl[1]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h0,    0, 0, 0,  0, 0, 32'h0,    0);
        tbl[2]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h0,    0, 0, 0,  0, 0, 32'h0,    0);
        tbl[3]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h0,    1, 0, 0,  0, 1, HA,       0);
        tbl[4]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h0,    0, 0, 0,  0, 1, 32'h0,    0);
        // exception inside the handler -> sticky double fault, no entry
        tbl[5]  = V(0, 1, A, 1, 0, 0, 1, 10, 0, 32'h3010, 32'h0,    0, 0, 0,  0, 1, 32'h0,    0);
        tbl[6]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h0,    0, 0, 0,  0, 1, 32'h0,    1);
        // eret, quiet RETURN cycle despite live interrupt, then re-entry
        tbl[7]  = V(0, 1, A, 1, 0, 0, 0, 0,  1, 32'h3010, 32'h3020, 0, 1, 0,  0, 1, 32'h3020, 1);
        tbl[8]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    1);
        tbl[9]  = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h3020, 1, 0, 0,  0, 1, HA,       1);
        // reset in the handler, then an eret that must be ignored
        tbl[10] = V(1, 0, A, 1, 0, 0, 0, 0,  0, 32'h3010, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    1);
        tbl[11] = V(0, 0, A, 1, 0, 0, 0, 0,  1, 32'h3010, 32'h3020, 0, 0, 0,  0, 0, 32'h0,    0);
        // exception held behind two bubbles
        tbl[12] = V(0, 0, 0, 0, 0, 1, 1, 10, 0, 32'h3024, 32'h3020, 0, 0, 0,  0, 0, 32'h0,    0);
        tbl[13] = V(0, 0, 0, 0, 0, 1, 1, 10, 0, 32'h3024, 32'h3020, 0, 0, 0,  0, 0, 32'h0,    0);
        tbl[14] = V(0, 0, 0, 1, 0, 1, 1, 10, 0, 32'h3024, 32'h3020, 1, 0, 10, 1, 0, HA,       0);
        tbl[15] = V(0, 1, A, 1, 0, 0, 0, 0,  1, 32'h3024, 32'h3028, 0, 1, 0,  0, 0, 32'h3028, 0);
        tbl[16] = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3024, 32'h3028, 0, 0, 0,  0, 0, 32'h0,    0);
        // simultaneous interrupt and exception: interrupt code wins
        tbl[17] = V(0, 1, A, 1, 0, 0, 1, 4,  0, 32'h3040, 32'h3028, 1, 0, 0,  0, 1, HA,       0);
        // stalled eret waits
        tbl[18] = V(0, 1, A, 1, 1, 0, 0, 0,  1, 32'h3040, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    0);
        tbl[19] = V(0, 1, A, 1, 0, 0, 0, 0,  1, 32'h3040, 32'h3020, 0, 1, 0,  0, 1, 32'h3020, 0);
        tbl[20] = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3040, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    0);
        tbl[21] = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3040, 32'h3020, 1, 0, 0,  0, 1, HA,       0);
        tbl[22] = V(0, 1, A, 1, 0, 0, 0, 0,  1, 32'h3040, 32'h3020, 0, 1, 0,  0, 1, 32'h3020, 0);
        tbl[23] = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3040, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    0);
        // pending interrupt held off by a stall
        tbl[24] = V(0, 1, A, 1, 1, 0, 0, 0,  0, 32'h3040, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    0);
        tbl[25] = V(0, 1, A, 1, 1, 0, 0, 0,  0, 32'h3040, 32'h3020, 0, 0, 0,  0, 1, 32'h0,    0);
        tbl[26] = V(0, 1, A, 1, 0, 0, 0, 0,  0, 32'h3040, 32'h3020, 1, 0, 0,  0, 1, HA,       0);

        for (int i = 0; i < 27; i++) begin
            vec_t t;
            t = tbl[i];
            @(negedge clk);
            drive(t.rst, t.hw, t.sr, t.vld, t.stl, t.bd, t.exc, t.code, t.eret, t.pc, t.epc);
            #1;
            check($sformatf("vec%0d", i), got_vec(),
                  {t.we1, t.we2, t.ex, t.ebd, t.pc, t.ehw, t.we1 | t.we2,
                   t.we1 | t.we2, t.rpc, t.df});
        end

        // randomized phase: start from a clean reset, then track with the model
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        busy = 0; cool = 0; mdf = 0;
        hq.delete();
        for (int i = 0; i < S; i++) hq.push_back(6'd0);

        for (int n = 0; n < 600; n++) begin
            logic        r, v, st, b, e, er;
            logic [5:0]  hw;
            logic [31:0] sr, pc, epc;
            logic [4:0]  code;
            logic        idle, ireq, ereq, tk, ert;
            logic [5:0]  mhw;
            logic [4:0]  ex;
            logic [31:0] rpc;

            @(negedge clk);
            r    = ($urandom_range(0, 63) == 0);
            hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            sr   = {$urandom} & 32'hFFFF_0000;
            sr[15:10] = 6'($urandom);
            sr[1] = ($urandom_range(0, 3) == 0);
            sr[0] = ($urandom_range(0, 3) != 0);
            v    = ($urandom_range(0, 3) != 0);
            st   = ($urandom_range(0, 3) == 0);
            b    = 1'($urandom);
            e    = ($urandom_range(0, 7) == 0);
            code = 5'($urandom);
            er   = ($urandom_range(0, 3) == 0);
            pc   = {$urandom} & 32'hFFFF_FFFC;
            epc  = {$urandom} & 32'hFFFF_FFFC;
            drive(r, hw, sr, v, st, b, e, code, er, pc, epc);
            #1;

            mhw  = hq[0];
            idle = !busy && !cool;
            ireq = idle && sr[0] && !sr[1] && ((mhw & sr[15:10]) != 0);
            ereq = idle && e;
            tk   = (ireq || ereq) && v && !st && !r;
            ert  = busy && er && v && !st && !r;
            ex   = tk ? (ireq ? 5'd0 : code) : 5'd0;
            rpc  = tk ? HA : (ert ? epc : 32'd0);
            check($sformatf("rand%0d", n), got_vec(),
                  {tk, ert, ex, tk & b, pc, mhw, tk | ert, tk | ert, rpc, mdf});

            // advance the model to the state after this clock edge
            if (r) begin
                busy = 0; cool = 0; mdf = 0;
                hq.delete();
                for (int i = 0; i < S; i++) hq.push_back(6'd0);
            end else begin
                mdf = mdf || (busy && e && v);
                hq.push_back(hw);
                void'(hq.pop_front());
                if (tk)        busy = 1;
                else if (ert)  begin busy = 0; cool = 1; end
                else if (cool) cool = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Exception/interrupt sequencer for the CP0 register block (SR/Cause/EPC).
- Sits beside the M stage and watches the M-stage instruction, CP0 SR and device interrupt lines.
- Decides when to take an interrupt or exception, and drives the CP0 entry (we1) and eret (we2) strobes, Cause fields and EPC source.
- Redirects the PC to the handler or to EPC, and flushes the pipeline.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt entry vector.
- SYNC_STAGES, 2, flop depth of the hwint synchronizer (legal values 1–3).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- hwint_raw  in  6  device interrupt lines, asynchronous to clk.
- sr  in  32  CP0 SR: IM=[15:10], EXL=[1], IE=[0].
- epc  in  32  CP0 EPC, used as the eret target.
- pc_m  in  32  PC of the M-stage instruction.
- valid_m  in  1  M stage holds a real instruction (not a bubble).
- stall_m  in  1  M stage is frozen this cycle.
- bd_m  in  1  M-stage instruction is in a delay slot.
- exc_valid_m  in  1  M-stage instruction raised an exception.
- exc_code_m  in  5  ExcCode for exc_valid_m.
- eret_m  in  1  M-stage instruction is eret.
- cp0_we1  out  1  CP0 exception-entry strobe.
- cp0_we2  out  1  CP0 eret strobe.
- cp0_ex  out  5  Cause.ExcCode value.
- cp0_bd  out  1  Cause.BD value.
- cp0_epc_in  out  32  EPC source; pc_m is passed unchanged, CP0 applies the -4 for BD.
- cp0_hwint  out  6  synchronized interrupt lines to Cause.IP.
- flush  out  1  kill F/D/E/M instructions this cycle.
- redirect_valid  out  1  PC override valid.
- redirect_pc  out  32  PC override target.
- double_fault  out  1  sticky error flag.

Behaviour:
- hwint_raw passes through SYNC_STAGES flops.
  - cp0_hwint is the last stage.
  - Reset clears all stages to 0.
- FSM state is one of IDLE, HANDLER, RETURN.
  - Reset puts the FSM in IDLE.
  - The FSM, not sr[1], gates entry. This closes the one-cycle window before the CP0 EXL write is visible.
- Conditions, all combinational:
  - int_req = state==IDLE & sr[0] & ~sr[1] & |(cp0_hwint & sr[15:10]).
  - exc_req = state==IDLE & exc_valid_m.
  - take = (int_req | exc_req) & valid_m & ~stall_m.
- A request held off by a bubble or a stall is not lost.
  - int_req is level-based and is re-evaluated every cycle.
  - exc_req follows the M-stage instruction.
- Priority: interrupt over exception in the same cycle.
  - Interrupt taken: cp0_ex=0.
  - Exception only: cp0_ex=exc_code_m.
- In a take cycle:
  - cp0_we1=1, cp0_bd=bd_m, cp0_epc_in=pc_m.
  - flush=1, redirect_valid=1, redirect_pc=HANDLER_ADDR.
  - Next state is HANDLER.
- HANDLER state:
  - No new entry is taken.
  - exc_valid_m & valid_m sets double_fault and is otherwise ignored (no we1, no redirect).
- HANDLER with eret_m & valid_m & ~stall_m:
  - cp0_we2=1, flush=1, redirect_valid=1, redirect_pc=epc.
  - Next state is RETURN.
- RETURN lasts exactly one cycle.
  - No entry, no eret.
  - Gives the CP0 EXL clear time to propagate.
  - Next state is IDLE.
- eret_m in IDLE is ignored: no strobe, no redirect.
- Default outputs in every other cycle:
  - cp0_we1, cp0_we2, flush, redirect_valid = 0.
  - cp0_ex = 0, cp0_bd = 0, redirect_pc = 0.
  - cp0_epc_in = pc_m.
- Reset outputs: all strobes 0, cp0_hwint=0, double_fault=0.
- double_fault is sticky and is cleared only by reset.
- Reset in HANDLER or RETURN returns the FSM to IDLE the next cycle. No we2 is issued.
- cp0_we1 and cp0_we2 are never high in the same cycle. Each is a single-cycle pulse per event.

Test Plan:
- Interrupt entry:
  - Stimulus: sr=32'h0000_0401 (IM[10], IE), hwint_raw=6'b000001, valid_m=1, pc_m=32'h3010.
  - Expected: exactly SYNC_STAGES cycles later, a one-cycle pulse with cp0_we1=1, cp0_ex=0, cp0_epc_in=32'h3010, redirect_pc=32'h4180, flush=1. State goes to HANDLER.
- Exception while in a bubble:
  - Stimulus: exc_valid_m=1, exc_code_m=5'd10, bd_m=1, pc_m=32'h3024. Hold valid_m=0 for 2 cycles, then 1.
  - Expected: we1 asserts only in the valid_m=1 cycle, with cp0_ex=10 and cp0_bd=1.
- Simultaneous interrupt and exception:
  - Stimulus: int_req and exc_valid_m (code 4) in the same cycle.
  - Expected: cp0_ex=0 with a single we1 pulse.
- Eret sequence:
  - Stimulus: in HANDLER, eret_m=1, epc=32'h3020.
  - Expected: cp0_we2=1, redirect_pc=32'h3020. The next cycle is RETURN with no entry even while the interrupt is still asserted. Entry is re-taken the cycle after if sr still enables it.
- Exception inside the handler:
  - Stimulus: in HANDLER, exc_valid_m=1, valid_m=1.
  - Expected: double_fault=1 and stays 1; no we1.
- Reset mid-handler:
  - Stimulus: reset=1 for 1 cycle while in HANDLER.
  - Expected: state IDLE, double_fault=0, cp0_hwint=0. A subsequent eret_m produces no we2.
- Stall:
  - Stimulus: stall_m=1 during a pending interrupt.
  - Expected: no we1 until stall_m=0.
